csel_pipe_adder: RTL

Parametrised, pipelined carry-select adder/subtractor with a valid/ready handshake on both sides. Operands are split into BLOCK_W-bit carry-select blocks. Groups of BLK_PER_STG blocks are resolved per pipeline stage, giving one result per clock at a fixed latency. It is the next-generation replacement for the fixed 4-bit combinational carry-select adder and is used wherever wide add/subtract must close timing at full clock rate.

---
 rtl/csel_pkg.sv | 29 ++
 rtl/csel_block.sv | 33 +++
 rtl/csel_pipe_adder.sv | 136 +++++++++++++
 3 files changed

// File: rtl/csel_pkg.sv
// rtl/csel_pkg.sv - shared constants, dimension helper and stage-register type for csel_pipe_adder
package csel_pkg;

    // Widest operand a stage register can carry; narrower instances zero-pad.
    localparam int MAX_W = 64;

    typedef struct packed {
        int nblk;
        int lat;
    } csel_dims_t;

    function automatic csel_dims_t csel_dims(input int width, input int block_w, input int blk_per_stg);
        csel_dims_t d;
        d.nblk = (block_w > 0) ? width / block_w : 1;
        d.lat  = (blk_per_stg > 0 && d.nblk >= blk_per_stg) ? d.nblk / blk_per_stg : 1;
        return d;
    endfunction

    typedef struct packed {
        logic [MAX_W-1:0] sum;
        logic [MAX_W-1:0] a;
        logic [MAX_W-1:0] b;
        logic             carry;
        logic             msb_carry;
        logic             ovf;
        logic             valid;
    } csel_stage_t;

endpackage

// File: rtl/csel_block.sv
// rtl/csel_block.sv - BLOCK_W-bit dual-ripple carry-select cell
module csel_block #(
    parameter int BLOCK_W = 4
) (
    input  logic [BLOCK_W-1:0] a,
    input  logic [BLOCK_W-1:0] b,
    input  logic               cin,
    output logic [BLOCK_W-1:0] s,
    output logic               cout
);

    logic [BLOCK_W-1:0] s0;
    logic [BLOCK_W-1:0] s1;
    logic               c0;
    logic               c1;

    always_comb begin
        s0 = '0;
        s1 = '0;
        c0 = 1'b0;
        c1 = 1'b1;
        for (int i = 0; i < BLOCK_W; i++) begin
            s0[i] = a[i] ^ b[i] ^ c0;
            c0    = (a[i] & b[i]) | (c0 & (a[i] ^ b[i]));
            s1[i] = a[i] ^ b[i] ^ c1;
            c1    = (a[i] & b[i]) | (c1 & (a[i] ^ b[i]));
        end
    end

    assign s    = cin ? s1 : s0;
    assign cout = cin ? c1 : c0;

endmodule

// File: rtl/csel_pipe_adder.sv
// rtl/csel_pipe_adder.sv - pipelined carry-select adder/subtractor with valid/ready handshake
module csel_pipe_adder
    import csel_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int BLOCK_W     = 4,
    parameter int BLK_PER_STG = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam csel_dims_t DIMS = csel_dims(WIDTH, BLOCK_W, BLK_PER_STG);
    localparam int NBLK = DIMS.nblk;
    localparam int LAT  = DIMS.lat;

    if (WIDTH < 1 || BLOCK_W < 1 || BLK_PER_STG < 1 || WIDTH > MAX_W ||
        (WIDTH % BLOCK_W) != 0 || ((WIDTH / BLOCK_W) % BLK_PER_STG) != 0) begin : g_bad_params
        $error("csel_pipe_adder: illegal WIDTH/BLOCK_W/BLK_PER_STG combination");
    end

    logic [WIDTH-1:0]   b_eff;
    logic               c_eff;
    logic [LAT:0]       rdy;
    logic [BLOCK_W-1:0] blk_s [NBLK];
    logic [NBLK-1:0]    blk_co;
    csel_stage_t        stg_q [LAT];

    assign b_eff    = sub ? ~b : b;
    assign c_eff    = sub | cin;
    assign rdy[LAT] = out_ready;
    assign in_ready = rdy[0];

    for (genvar k = 0; k < LAT; k++) begin : g_stg
        localparam bit LAST = (k == LAT - 1);

        logic [WIDTH-1:0] op_a;
        logic [WIDTH-1:0] op_b;
        logic [WIDTH-1:0] sum_prev;
        logic [WIDTH-1:0] sum_new;
        logic             op_c;
        logic             up_valid;
        logic             stg_carry;
        logic             msb_c;
        logic             unused_stg;
        csel_stage_t      st_d;
        csel_stage_t      st_q;

        if (k == 0) begin : g_first
            assign op_a     = a;
            assign op_b     = b_eff;
            assign op_c     = c_eff;
            assign sum_prev = '0;
            assign up_valid = in_valid;
        end else begin : g_next
            assign op_a     = stg_q[k-1].a[WIDTH-1:0];
            assign op_b     = stg_q[k-1].b[WIDTH-1:0];
            assign op_c     = stg_q[k-1].carry;
            assign sum_prev = stg_q[k-1].sum[WIDTH-1:0];
            assign up_valid = stg_q[k-1].valid;
        end

        for (genvar j = 0; j < BLK_PER_STG; j++) begin : g_blk
            localparam int BI = k * BLK_PER_STG + j;
            logic blk_cin;
            if (j == 0) begin : g_cin_stage
                assign blk_cin = op_c;
            end else begin : g_cin_chain
                assign blk_cin = blk_co[BI-1];
            end
            csel_block #(.BLOCK_W(BLOCK_W)) u_blk (
                .a    (op_a[BI*BLOCK_W +: BLOCK_W]),
                .b    (op_b[BI*BLOCK_W +: BLOCK_W]),
                .cin  (blk_cin),
                .s    (blk_s[BI]),
                .cout (blk_co[BI])
            );
        end

        always_comb begin
            sum_new = sum_prev;
            for (int j = 0; j < BLK_PER_STG; j++) begin
                sum_new[(k*BLK_PER_STG+j)*BLOCK_W +: BLOCK_W] = blk_s[k*BLK_PER_STG+j];
            end
        end

        assign stg_carry = blk_co[k*BLK_PER_STG+BLK_PER_STG-1];
        // Carry into the MSB, recovered from the MSB sum bit and its operands.
        assign msb_c     = sum_new[WIDTH-1] ^ op_a[WIDTH-1] ^ op_b[WIDTH-1];

        // Data fields only load with a valid transfer so bubbles leave outputs steady.
        always_comb begin
            st_d = st_q;
            if (rdy[k]) begin
                st_d.valid = up_valid;
                if (up_valid) begin
                    st_d.sum       = MAX_W'(sum_new);
                    st_d.a         = MAX_W'(op_a);
                    st_d.b         = MAX_W'(op_b);
                    st_d.carry     = stg_carry;
                    st_d.msb_carry = LAST ? msb_c : 1'b0;
                    st_d.ovf       = LAST ? (msb_c ^ stg_carry) : 1'b0;
                end
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                st_q <= '0;
            end else begin
                st_q <= st_d;
            end
        end

        assign stg_q[k]   = st_q;
        assign rdy[k]     = ~st_q.valid | rdy[k+1];
        assign unused_stg = ^st_q;
    end

    assign out_valid = stg_q[LAT-1].valid;
    assign sum       = stg_q[LAT-1].sum[WIDTH-1:0];
    assign cout      = stg_q[LAT-1].carry;
    assign ovf       = stg_q[LAT-1].ovf;

endmodule
